// File: rtl/uart_mmio_ctrl_if.sv
// CPU-side register bus for the UART MMIO controller.
// The master drives address/strobes/write data; the slave returns read data and the interrupt.
interface uart_mmio_ctrl_if;
    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    modport master (output bus_addr, bus_wr, bus_rd, bus_wdata, input bus_rdata, irq);
    modport slave  (input bus_addr, bus_wr, bus_rd, bus_wdata, output bus_rdata, irq);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX/RX byte FIFOs, CON register, a sender sequencing
// FSM with a busy watchdog, and a registered level interrupt.
//
// state       | meaning
// S_IDLE      | waiting for a queued byte and an idle sender
// S_LOAD      | byte latched on tx_data, tx_en pulsed
// S_WAIT_BUSY | waiting for the sender to go busy, watchdog running
// S_WAIT_DONE | sender busy, waiting for it to return idle
module uart_mmio_ctrl #(
    parameter int TX_DEPTH     = 4,
    parameter int RX_DEPTH     = 4,
    parameter int BUSY_TIMEOUT = 4095
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_mmio_ctrl_if.slave   bus,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_status,
    input  logic [7:0]        rx_data,
    input  logic              rx_status
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int WDW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TXA:0] TX_FULL_CNT = (TXA + 1)'(TX_DEPTH);
    localparam logic [RXA:0] RX_FULL_CNT = (RXA + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t           state;
    logic [WDW-1:0]   wd_cnt;
    logic             tx_meta, tx_s, rx_meta, rx_s, rx_s_d;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TXA-1:0]   tx_wp, tx_rp;
    logic [RXA-1:0]   rx_wp, rx_rp;
    logic [TXA:0]     tx_cnt;
    logic [RXA:0]     rx_cnt;
    logic             rx_ie, tx_ie, rx_ovr, tx_ovf, tx_tmo, irq_q;

    logic wr_txd, rd_rxd, wr_con;
    logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
    logic tx_pop, tx_push, tx_ovf_set, rx_req, rx_pop, rx_push, rx_ovr_set, tx_tmo_set;
    logic [31:0] con_val;
    logic unused_wdata;

    assign unused_wdata = &{1'b0, bus.bus_wdata[31:8]};

    assign wr_txd = bus.bus_wr && (bus.bus_addr == 2'd0);
    assign rd_rxd = bus.bus_rd && (bus.bus_addr == 2'd1);
    assign wr_con = bus.bus_wr && (bus.bus_addr == 2'd2);

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == TX_FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_FULL_CNT);
    assign tx_idle  = tx_empty && (state == S_IDLE);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_pop     = (state == S_IDLE) && !tx_empty && tx_s;
    assign tx_push    = wr_txd && (!tx_full || tx_pop);
    assign tx_ovf_set = wr_txd && !tx_push;

    assign rx_req     = rx_s && !rx_s_d;
    assign rx_pop     = rd_rxd && !rx_empty;
    assign rx_push    = rx_req && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_req && !rx_push;

    assign tx_tmo_set = (state == S_WAIT_BUSY) && tx_s && (wd_cnt == WDW'(1));

    assign con_val = {24'b0, tx_tmo, tx_ovf, rx_ovr, tx_idle, tx_full, !rx_empty, tx_ie, rx_ie};
    assign bus.irq = irq_q;

    always_comb begin
        bus.bus_rdata = '0;
        if (bus.bus_rd) begin
            case (bus.bus_addr)
                2'd1:    if (!rx_empty) bus.bus_rdata = {24'b0, rx_mem[rx_rp]};
                2'd2:    bus.bus_rdata = con_val;
                default: bus.bus_rdata = '0;
            endcase
        end
    end

    // Synchronisers reset to the inputs' idle levels so reset release creates no edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_meta <= 1'b1;
            tx_s    <= 1'b1;
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            rx_s_d  <= 1'b0;
        end else begin
            tx_meta <= tx_status;
            tx_s    <= tx_meta;
            rx_meta <= rx_status;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    always_ff @(posedge sysclk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.bus_wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
            wd_cnt  <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                S_IDLE: if (tx_pop) begin
                    tx_data <= tx_mem[tx_rp];
                    tx_en   <= 1'b1;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    wd_cnt <= WDW'(BUSY_TIMEOUT);
                    state  <= S_WAIT_BUSY;
                end
                // Down-counter: the last watchdog cycle is the one holding 1.
                S_WAIT_BUSY: begin
                    if (!tx_s)                   state  <= S_WAIT_DONE;
                    else if (wd_cnt == WDW'(1))  state  <= S_IDLE;
                    else                         wd_cnt <= wd_cnt - 1'b1;
                end
                S_WAIT_DONE: if (tx_s) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as a write-1-clear wins.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_ie  <= 1'b0;
            tx_ie  <= 1'b0;
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
            tx_tmo <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_con) begin
                rx_ie <= bus.bus_wdata[0];
                tx_ie <= bus.bus_wdata[1];
            end
            rx_ovr <= rx_ovr_set || (rx_ovr && !(wr_con && bus.bus_wdata[5]));
            tx_ovf <= tx_ovf_set || (tx_ovf && !(wr_con && bus.bus_wdata[6]));
            tx_tmo <= tx_tmo_set || (tx_tmo && !(wr_con && bus.bus_wdata[7]));
            irq_q  <= (rx_ie && !rx_empty) || (tx_ie && tx_idle);
        end
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: register vector table plus hand-written
// sequences for transmit latency, overflow, receive, watchdog, interrupt and reset.
module tb_uart_mmio_ctrl;
    logic       sysclk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic [7:0] rx_data;
    logic       rx_status;

    uart_mmio_ctrl_if bif ();

    uart_mmio_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4), .BUSY_TIMEOUT(4095)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .bus      (bif.slave),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_status(tx_status),
        .rx_data  (rx_data),
        .rx_status(rx_status)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t       tbl [13];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] sent [$];
    bit         auto_en = 1'b0;
    int         busy_len = 40;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // All bus tasks are entered at a negedge and return at a negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bif.bus_addr  = a;
        bif.bus_wdata = d;
        bif.bus_wr    = 1'b1;
        @(negedge sysclk);
        bif.bus_wr    = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        bif.bus_addr = a;
        bif.bus_rd   = 1'b1;
        #2;
        chk(nm, bif.bus_rdata, exp);
        @(negedge sysclk);
        bif.bus_rd   = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data   = d;
        rx_status = 1'b1;
        repeat (3) @(negedge sysclk);
        rx_status = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    task automatic wait_tx_en(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge sysclk);
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    always @(negedge sysclk) if (tx_en) sent.push_back(tx_data);

    // Sender model: goes busy 3 cycles after a start pulse, stays busy busy_len cycles.
    always begin
        @(negedge sysclk);
        if (auto_en && tx_en) begin
            repeat (3) @(negedge sysclk);
            tx_status = 1'b0;
            repeat (busy_len) @(negedge sysclk);
            tx_status = 1'b1;
        end
    end

    initial begin
        int sz;
        tbl[0]  = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0010};
        tbl[1]  = '{2'd2, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0000};
        tbl[2]  = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013};
        tbl[3]  = '{2'd3, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[4]  = '{2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013};
        tbl[6]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[7]  = '{2'd1, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[8]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[9]  = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0010};
        tbl[10] = '{2'd2, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0010};
        tbl[11] = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0011};
        tbl[12] = '{2'd2, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0011};

        reset = 1'b1;
        tx_status = 1'b1;
        rx_status = 1'b0;
        rx_data = 8'h00;
        bif.bus_addr = 2'd2;
        bif.bus_wr = 1'b0;
        bif.bus_rd = 1'b0;
        bif.bus_wdata = '0;
        #12;
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_irq", 32'(bif.irq), 32'd0);
        chk("rst_rdata_no_rd", bif.bus_rdata, 32'd0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);

        for (int i = 0; i < 13; i++) begin
            bif.bus_addr  = tbl[i].addr;
            bif.bus_wr    = tbl[i].wr;
            bif.bus_rd    = tbl[i].rd;
            bif.bus_wdata = tbl[i].wdata;
            if (tbl[i].rd) begin
                #2;
                chk($sformatf("vec%0d", i), bif.bus_rdata, tbl[i].exp);
            end
            @(negedge sysclk);
            bif.bus_wr = 1'b0;
            bif.bus_rd = 1'b0;
        end
        rd_chk("con_after_tbl", 2'd2, 32'h10);

        // Single byte, exact tx_en latency, then a 40-cycle busy sender.
        busy_len = 40;
        auto_en  = 1'b1;
        sent.delete();
        bus_write(2'd0, 32'h55);
        chk("lat_n1_tx_en", 32'(tx_en), 32'd0);
        @(negedge sysclk);
        chk("lat_n2_tx_en", 32'(tx_en), 32'd1);
        chk("lat_n2_tx_data", 32'(tx_data), 32'h55);
        @(negedge sysclk);
        chk("lat_n3_tx_en", 32'(tx_en), 32'd0);
        repeat (10) @(negedge sysclk);
        rd_chk("con_busy", 2'd2, 32'h00);
        repeat (45) @(negedge sysclk);
        rd_chk("con_back_idle", 2'd2, 32'h10);
        chk("one_sent", 32'(sent.size()), 32'd1);
        auto_en = 1'b0;

        // Six writes with the sender held busy: one in flight, four queued, one dropped.
        sent.delete();
        bus_write(2'd0, 32'h01);
        wait_tx_en("ovf_first_tx_en");
        tx_status = 1'b0;
        for (int b = 2; b <= 6; b++) bus_write(2'd0, 32'(b));
        rd_chk("con_full_ovf", 2'd2, 32'h48);
        busy_len = 5;
        auto_en  = 1'b1;
        tx_status = 1'b1;
        for (int i = 0; i < 1000 && sent.size() < 5; i++) @(negedge sysclk);
        repeat (60) @(negedge sysclk);
        chk("ovf_sent_count", 32'(sent.size()), 32'd5);
        sz = sent.size();
        for (int i = 0; i < 5; i++)
            if (i < sz) chk($sformatf("ovf_order%0d", i), 32'(sent[i]), 32'(i + 1));
        rd_chk("con_ovf_idle", 2'd2, 32'h50);
        bus_write(2'd2, 32'h40);
        rd_chk("con_ovf_clr", 2'd2, 32'h10);
        auto_en = 1'b0;

        // Two received bytes, read back, then an empty read.
        rx_pulse(8'hA3);
        rx_pulse(8'h5C);
        rd_chk("rx_ne", 2'd2, 32'h14);
        rd_chk("rx_a3", 2'd1, 32'hA3);
        rd_chk("rx_5c", 2'd1, 32'h5C);
        rd_chk("rx_empty_rd", 2'd1, 32'h00);
        rd_chk("rx_empty_con", 2'd2, 32'h10);

        // RX overrun, then a read coinciding with a capture into the full FIFO.
        for (int b = 0; b < 5; b++) rx_pulse(8'h10 + 8'(b));
        rd_chk("rx_ovr_set", 2'd2, 32'h34);
        bus_write(2'd2, 32'h20);
        rd_chk("rx_ovr_clr", 2'd2, 32'h14);
        rx_data   = 8'h99;
        rx_status = 1'b1;
        repeat (2) @(negedge sysclk);
        bif.bus_addr = 2'd1;
        bif.bus_rd   = 1'b1;
        #2;
        chk("rx_simul_rd", bif.bus_rdata, 32'h10);
        @(negedge sysclk);
        bif.bus_rd = 1'b0;
        rx_status  = 1'b0;
        repeat (3) @(negedge sysclk);
        rd_chk("rx_simul_con", 2'd2, 32'h14);
        rd_chk("rx_q1", 2'd1, 32'h11);
        rd_chk("rx_q2", 2'd1, 32'h12);
        rd_chk("rx_q3", 2'd1, 32'h13);
        rd_chk("rx_q4", 2'd1, 32'h99);
        rd_chk("rx_q_empty", 2'd1, 32'h00);

        // Sender never goes busy: watchdog expires after 4095 WAIT_BUSY cycles.
        sent.delete();
        bus_write(2'd0, 32'h77);
        wait_tx_en("tmo_tx_en");
        repeat (4095) @(negedge sysclk);
        bif.bus_addr = 2'd2;
        bif.bus_rd   = 1'b1;
        #2;
        chk("tmo_last_wait", bif.bus_rdata, 32'h00);
        @(negedge sysclk);
        #2;
        chk("tmo_fired", bif.bus_rdata, 32'h90);
        @(negedge sysclk);
        bif.bus_rd = 1'b0;
        bus_write(2'd2, 32'h80);
        rd_chk("tmo_clr", 2'd2, 32'h10);

        // Interrupt: TX_IE with TX idle, then RX_IE with a received byte.
        bus_write(2'd2, 32'h3);
        chk("irq_lag", 32'(bif.irq), 32'd0);
        @(negedge sysclk);
        chk("irq_tx_idle", 32'(bif.irq), 32'd1);
        bus_write(2'd2, 32'h0);
        @(negedge sysclk);
        chk("irq_off", 32'(bif.irq), 32'd0);
        bus_write(2'd2, 32'h1);
        rx_pulse(8'h3C);
        chk("irq_rx", 32'(bif.irq), 32'd1);
        rd_chk("irq_rx_byte", 2'd1, 32'h3C);
        repeat (2) @(negedge sysclk);
        chk("irq_rx_clr", 32'(bif.irq), 32'd0);

        // Reset during WAIT_DONE with two bytes queued and one RX byte pending.
        rx_pulse(8'hC7);
        chk("pre_rst_irq", 32'(bif.irq), 32'd1);
        sent.delete();
        bus_write(2'd0, 32'hA1);
        wait_tx_en("rst_seq_tx_en");
        tx_status = 1'b0;
        bus_write(2'd0, 32'hA2);
        bus_write(2'd0, 32'hA3);
        repeat (4) @(negedge sysclk);
        reset = 1'b1;
        tx_status = 1'b1;
        #1;
        chk("midrst_tx_en", 32'(tx_en), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_irq", 32'(bif.irq), 32'd0);
        chk("midrst_rdata", bif.bus_rdata, 32'd0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        repeat (30) @(negedge sysclk);
        chk("no_tx_after_rst", 32'(sent.size()), 32'd1);
        rd_chk("con_after_rst", 2'd2, 32'h10);
        rd_chk("rx_after_rst", 2'd1, 32'h00);
        bus_write(2'd0, 32'hB5);
        wait_tx_en("post_rst_tx_en");
        chk("post_rst_tx_data", 32'(tx_data), 32'hB5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
